// File: rtl/sy_pkg.sv
// Shared types and sizing for the sy pipeline: physical register width,
// default reorder-buffer depth and the reorder-buffer entry layout.
package sy_pkg;

    localparam int PHY_REG_WTH       = 7;
    localparam int ROB_DEPTH_DEFAULT = 16;

    typedef struct packed {
        logic                   valid;
        logic                   done;
        logic                   exc;
        logic                   rdst_en;
        logic                   fp;
        logic [4:0]             arc;
        logic [PHY_REG_WTH-1:0] phy;
        logic [PHY_REG_WTH-1:0] old_phy;
    } rob_entry_t;

endpackage

// File: rtl/sy_ppl_rob_commit_if.sv
// Allocate / writeback / commit bundle between rename-dispatch-execute (master)
// and the reorder buffer commit unit (slave).
interface sy_ppl_rob_commit_if #(
    parameter int ROB_DEPTH = sy_pkg::ROB_DEPTH_DEFAULT
);
    import sy_pkg::*;

    localparam int ROB_IDX_WTH = $clog2(ROB_DEPTH);

    logic                   flush_i;
    logic                   alloc_en_i;
    logic                   alloc_ready_o;
    logic [ROB_IDX_WTH-1:0] alloc_rob_idx_o;
    logic                   alloc_rdst_en_i;
    logic                   alloc_rdst_fp_i;
    logic [4:0]             alloc_arc_rdst_i;
    logic [PHY_REG_WTH-1:0] alloc_phy_rdst_i;
    logic [PHY_REG_WTH-1:0] alloc_phy_old_i;
    logic                   wb_en_i;
    logic [ROB_IDX_WTH-1:0] wb_rob_idx_i;
    logic                   wb_exc_i;
    logic                   rob_update_arat_en_o;
    logic                   rob_update_fp_reg_o;
    logic [4:0]             rob_update_arat_arc_o;
    logic [PHY_REG_WTH-1:0] rob_update_arat_phy_o;
    logic [PHY_REG_WTH-1:0] rob_update_arat_old_phy_o;
    logic                   commit_valid_o;
    logic                   flush_o;
    logic                   empty_o;

    modport master (
        output flush_i, alloc_en_i, alloc_rdst_en_i, alloc_rdst_fp_i,
               alloc_arc_rdst_i, alloc_phy_rdst_i, alloc_phy_old_i,
               wb_en_i, wb_rob_idx_i, wb_exc_i,
        input  alloc_ready_o, alloc_rob_idx_o,
               rob_update_arat_en_o, rob_update_fp_reg_o, rob_update_arat_arc_o,
               rob_update_arat_phy_o, rob_update_arat_old_phy_o,
               commit_valid_o, flush_o, empty_o
    );

    modport slave (
        input  flush_i, alloc_en_i, alloc_rdst_en_i, alloc_rdst_fp_i,
               alloc_arc_rdst_i, alloc_phy_rdst_i, alloc_phy_old_i,
               wb_en_i, wb_rob_idx_i, wb_exc_i,
        output alloc_ready_o, alloc_rob_idx_o,
               rob_update_arat_en_o, rob_update_fp_reg_o, rob_update_arat_arc_o,
               rob_update_arat_phy_o, rob_update_arat_old_phy_o,
               commit_valid_o, flush_o, empty_o
    );

endinterface

// File: rtl/sy_ppl_rob_ptr.sv
// Head/tail/occupancy tracking for the reorder buffer. Full and empty come
// from the occupancy count so a wrapped tail equal to head is never ambiguous.
module sy_ppl_rob_ptr
    import sy_pkg::*;
#(
    parameter  int ROB_DEPTH   = ROB_DEPTH_DEFAULT,
    localparam int ROB_IDX_WTH = $clog2(ROB_DEPTH),
    localparam int CNT_WTH     = ROB_IDX_WTH + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   alloc_fire,
    input  logic                   commit_fire,
    output logic [ROB_IDX_WTH-1:0] head,
    output logic [ROB_IDX_WTH-1:0] tail,
    output logic                   full,
    output logic                   empty
);

    localparam logic [ROB_IDX_WTH-1:0] IDX_ONE  = ROB_IDX_WTH'(1);
    localparam logic [CNT_WTH-1:0]     CNT_ONE  = CNT_WTH'(1);
    localparam logic [CNT_WTH-1:0]     CNT_FULL = CNT_WTH'(ROB_DEPTH);

    logic [CNT_WTH-1:0] count;

    // Advance pointers and occupancy; reset and any flush return everything to zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + IDX_ONE;
            end
            if (commit_fire) begin
                head <= head + IDX_ONE;
            end
            if (alloc_fire && !commit_fire) begin
                count <= count + CNT_ONE;
            end else if (commit_fire && !alloc_fire) begin
                count <= count - CNT_ONE;
            end
        end
    end

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

endmodule

// File: rtl/sy_ppl_rob_commit.sv
// In-order reorder buffer and commit unit: allocates entries from rename,
// marks them done on writeback and retires one per cycle from the head,
// driving the architectural RAT / free-list update or an exception flush.
// Optional feature macro: SY_ROB_PERF_CNT_EN adds 64-bit commit and
// ROB-full cycle counters that only reset clears.
module sy_ppl_rob_commit
    import sy_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    sy_ppl_rob_commit_if.slave rob_if
`ifdef SY_ROB_PERF_CNT_EN
    ,
    output logic [63:0]        perf_commit_cnt_o,
    output logic [63:0]        perf_full_cycle_cnt_o
`endif
);

    localparam int ROB_IDX_WTH = $clog2(ROB_DEPTH);

    rob_entry_t             rob_q [ROB_DEPTH];
    rob_entry_t             head_entry;
    logic [ROB_IDX_WTH-1:0] head;
    logic [ROB_IDX_WTH-1:0] tail;
    logic                   full;
    logic                   empty;
    logic                   head_ready;
    logic                   commit_fire;
    logic                   exc_flush;
    logic                   alloc_fire;
    logic                   clr_all;

    sy_ppl_rob_ptr #(
        .ROB_DEPTH (ROB_DEPTH)
    ) u_ptr (
        .clk         (clk_i),
        .rst         (rst_i),
        .clr         (clr_all),
        .alloc_fire  (alloc_fire),
        .commit_fire (commit_fire),
        .head        (head),
        .tail        (tail),
        .full        (full),
        .empty       (empty)
    );

    // Decide this cycle's actions; external flush beats the exception flush, which beats everything else.
    always_comb begin
        head_entry  = rob_q[head];
        head_ready  = head_entry.valid && head_entry.done;
        commit_fire = !rob_if.flush_i && head_ready && !head_entry.exc;
        exc_flush   = !rob_if.flush_i && head_ready && head_entry.exc;
        alloc_fire  = rob_if.alloc_en_i && !full && !rob_if.flush_i && !exc_flush;
        clr_all     = rob_if.flush_i || exc_flush;
    end

    // Entry storage: writeback marks completion, commit retires the head, allocate fills the tail.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_all) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= '0;
            end
        end else begin
            if (rob_if.wb_en_i && rob_q[rob_if.wb_rob_idx_i].valid) begin
                rob_q[rob_if.wb_rob_idx_i].done <= 1'b1;
                rob_q[rob_if.wb_rob_idx_i].exc  <= rob_if.wb_exc_i;
            end
            if (commit_fire) begin
                rob_q[head] <= '0;
            end
            if (alloc_fire) begin
                rob_q[tail].valid   <= 1'b1;
                rob_q[tail].done    <= 1'b0;
                rob_q[tail].exc     <= 1'b0;
                rob_q[tail].rdst_en <= rob_if.alloc_rdst_en_i;
                rob_q[tail].fp      <= rob_if.alloc_rdst_fp_i;
                rob_q[tail].arc     <= rob_if.alloc_arc_rdst_i;
                rob_q[tail].phy     <= rob_if.alloc_phy_rdst_i;
                rob_q[tail].old_phy <= rob_if.alloc_phy_old_i;
            end
        end
    end

    // Registered single-cycle commit pulses; data fields stay zero unless a register update happens.
    always_ff @(posedge clk_i) begin
        if (rst_i || rob_if.flush_i) begin
            rob_if.commit_valid_o            <= 1'b0;
            rob_if.rob_update_arat_en_o      <= 1'b0;
            rob_if.rob_update_fp_reg_o       <= 1'b0;
            rob_if.rob_update_arat_arc_o     <= '0;
            rob_if.rob_update_arat_phy_o     <= '0;
            rob_if.rob_update_arat_old_phy_o <= '0;
            rob_if.flush_o                   <= 1'b0;
        end else begin
            rob_if.commit_valid_o <= commit_fire;
            rob_if.flush_o        <= exc_flush;
            if (commit_fire && head_entry.rdst_en) begin
                rob_if.rob_update_arat_en_o      <= 1'b1;
                rob_if.rob_update_fp_reg_o       <= head_entry.fp;
                rob_if.rob_update_arat_arc_o     <= head_entry.arc;
                rob_if.rob_update_arat_phy_o     <= head_entry.phy;
                rob_if.rob_update_arat_old_phy_o <= head_entry.old_phy;
            end else begin
                rob_if.rob_update_arat_en_o      <= 1'b0;
                rob_if.rob_update_fp_reg_o       <= 1'b0;
                rob_if.rob_update_arat_arc_o     <= '0;
                rob_if.rob_update_arat_phy_o     <= '0;
                rob_if.rob_update_arat_old_phy_o <= '0;
            end
        end
    end

    assign rob_if.alloc_ready_o   = !full;
    assign rob_if.alloc_rob_idx_o = tail;
    assign rob_if.empty_o         = empty;

`ifdef SY_ROB_PERF_CNT_EN
    // Performance counters survive pipeline flushes; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_commit_cnt_o     <= '0;
            perf_full_cycle_cnt_o <= '0;
        end else begin
            if (commit_fire) begin
                perf_commit_cnt_o <= perf_commit_cnt_o + 64'd1;
            end
            if (full) begin
                perf_full_cycle_cnt_o <= perf_full_cycle_cnt_o + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sy_ppl_rob_commit.sv
// Directed bench for sy_ppl_rob_commit: a queue-based program-order model
// predicts every output each cycle, and literal checks pin the model at
// the key points of each scenario.
module tb_sy_ppl_rob_commit;
    import sy_pkg::*;

    localparam int DEPTH = 16;
    localparam int IDX_W = $clog2(DEPTH);

    logic clk;
    logic rst;

    sy_ppl_rob_commit_if #(.ROB_DEPTH(DEPTH)) rob_if ();

`ifdef SY_ROB_PERF_CNT_EN
    logic [63:0] perf_commit_cnt;
    logic [63:0] perf_full_cycle_cnt;
`endif

    sy_ppl_rob_commit #(
        .ROB_DEPTH (DEPTH)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .rob_if (rob_if)
`ifdef SY_ROB_PERF_CNT_EN
        ,
        .perf_commit_cnt_o     (perf_commit_cnt),
        .perf_full_cycle_cnt_o (perf_full_cycle_cnt)
`endif
    );

    typedef struct {
        int idx;
        bit rdst_en;
        bit fp;
        int arc;
        int phy;
        int old_phy;
        bit done;
        bit exc;
    } mdl_entry_t;

    mdl_entry_t mdl_q[$];
    int mdl_next_idx;
    int exp_commit, exp_arat_en, exp_fp, exp_arc, exp_phy, exp_old, exp_flush;
    int vec_count;
    int miscompares;
    bit check_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Program-order model: the queue holds in-flight instructions oldest first.
    always @(posedge clk) begin : model
        mdl_entry_t e;
        bit was_full;
        bit exc_hit;
        was_full    = (mdl_q.size() == DEPTH);
        exc_hit     = 1'b0;
        exp_commit  = 0;
        exp_arat_en = 0;
        exp_fp      = 0;
        exp_arc     = 0;
        exp_phy     = 0;
        exp_old     = 0;
        exp_flush   = 0;
        if (rst || rob_if.flush_i) begin
            mdl_q.delete();
            mdl_next_idx = 0;
        end else begin
            if (mdl_q.size() > 0 && mdl_q[0].done) begin
                e = mdl_q[0];
                if (e.exc) begin
                    exp_flush    = 1;
                    exc_hit      = 1'b1;
                    mdl_q.delete();
                    mdl_next_idx = 0;
                end else begin
                    exp_commit = 1;
                    if (e.rdst_en) begin
                        exp_arat_en = 1;
                        exp_fp      = int'(e.fp);
                        exp_arc     = e.arc;
                        exp_phy     = e.phy;
                        exp_old     = e.old_phy;
                    end
                    mdl_q.delete(0);
                end
            end
            if (!exc_hit) begin
                if (rob_if.wb_en_i) begin
                    foreach (mdl_q[i]) begin
                        if (mdl_q[i].idx == int'(rob_if.wb_rob_idx_i)) begin
                            e        = mdl_q[i];
                            e.done   = 1'b1;
                            e.exc    = rob_if.wb_exc_i;
                            mdl_q[i] = e;
                        end
                    end
                end
                if (rob_if.alloc_en_i && !was_full) begin
                    e.idx     = mdl_next_idx;
                    e.rdst_en = rob_if.alloc_rdst_en_i;
                    e.fp      = rob_if.alloc_rdst_fp_i;
                    e.arc     = int'(rob_if.alloc_arc_rdst_i);
                    e.phy     = int'(rob_if.alloc_phy_rdst_i);
                    e.old_phy = int'(rob_if.alloc_phy_old_i);
                    e.done    = 1'b0;
                    e.exc     = 1'b0;
                    mdl_q.push_back(e);
                    mdl_next_idx = (mdl_next_idx + 1) % DEPTH;
                end
            end
        end
    end

    // Compare every DUT output against the model halfway through each cycle.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("commit_valid", 32'(rob_if.commit_valid_o), 32'(exp_commit));
            checkOutput("arat_en", 32'(rob_if.rob_update_arat_en_o), 32'(exp_arat_en));
            checkOutput("fp_reg", 32'(rob_if.rob_update_fp_reg_o), 32'(exp_fp));
            checkOutput("arat_arc", 32'(rob_if.rob_update_arat_arc_o), 32'(exp_arc));
            checkOutput("arat_phy", 32'(rob_if.rob_update_arat_phy_o), 32'(exp_phy));
            checkOutput("arat_old_phy", 32'(rob_if.rob_update_arat_old_phy_o), 32'(exp_old));
            checkOutput("flush_o", 32'(rob_if.flush_o), 32'(exp_flush));
            checkOutput("alloc_ready", 32'(rob_if.alloc_ready_o), 32'(mdl_q.size() != DEPTH));
            checkOutput("alloc_idx", 32'(rob_if.alloc_rob_idx_o), 32'(mdl_next_idx));
            checkOutput("empty", 32'(rob_if.empty_o), 32'(mdl_q.size() == 0));
        end
    end

    task automatic applyStimulus(input bit flush, input bit alloc, input bit rdst_en, input bit fp,
                                 input int arc, input int phy, input int old_phy,
                                 input bit wb, input int wb_idx, input bit wb_exc);
        rob_if.flush_i          = flush;
        rob_if.alloc_en_i       = alloc;
        rob_if.alloc_rdst_en_i  = rdst_en;
        rob_if.alloc_rdst_fp_i  = fp;
        rob_if.alloc_arc_rdst_i = 5'(arc);
        rob_if.alloc_phy_rdst_i = PHY_REG_WTH'(phy);
        rob_if.alloc_phy_old_i  = PHY_REG_WTH'(old_phy);
        rob_if.wb_en_i          = wb;
        rob_if.wb_rob_idx_i     = IDX_W'(wb_idx);
        rob_if.wb_exc_i         = wb_exc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doIdle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doAlloc(input bit rdst_en, input bit fp, input int arc, input int phy, input int old_phy);
        applyStimulus(0, 1, rdst_en, fp, arc, phy, old_phy, 0, 0, 0);
    endtask

    task automatic doWb(input int idx, input bit exc);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, idx, exc);
    endtask

    task automatic doFlush();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vec_count    = 0;
        miscompares  = 0;
        check_en     = 1'b0;
        mdl_next_idx = 0;
        rst          = 1'b1;
        doIdle();
        doIdle();
        check_en = 1'b1;
        checkOutput("reset_ready", 32'(rob_if.alloc_ready_o), 32'd1);
        checkOutput("reset_empty", 32'(rob_if.empty_o), 32'd1);
        checkOutput("reset_idx", 32'(rob_if.alloc_rob_idx_o), 32'd0);
        checkOutput("reset_commit", 32'(rob_if.commit_valid_o), 32'd0);
        rst = 1'b0;

        $display("[TB] in-order commit of out-of-order writebacks");
        doAlloc(1, 0, 5, 40, 5);
        doAlloc(1, 0, 6, 41, 6);
        doAlloc(1, 0, 7, 42, 7);
        doWb(2, 0);
        doWb(0, 0);
        doWb(1, 0);
        checkOutput("s1_arc0", 32'(rob_if.rob_update_arat_arc_o), 32'd5);
        checkOutput("s1_old0", 32'(rob_if.rob_update_arat_old_phy_o), 32'd5);
        checkOutput("s1_fp0", 32'(rob_if.rob_update_fp_reg_o), 32'd0);
        doIdle();
        checkOutput("s1_arc1", 32'(rob_if.rob_update_arat_arc_o), 32'd6);
        checkOutput("s1_phy1", 32'(rob_if.rob_update_arat_phy_o), 32'd41);
        doIdle();
        checkOutput("s1_arc2", 32'(rob_if.rob_update_arat_arc_o), 32'd7);
        checkOutput("s1_old2", 32'(rob_if.rob_update_arat_old_phy_o), 32'd7);
        doIdle();
        checkOutput("s1_empty", 32'(rob_if.empty_o), 32'd1);

        $display("[TB] fill to full and drain one");
        rst = 1'b1;
        doIdle();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            doAlloc(1, 0, i, 64 + i, i);
        end
        checkOutput("s2_not_ready", 32'(rob_if.alloc_ready_o), 32'd0);
        doAlloc(1, 0, 31, 99, 31);
        checkOutput("s2_idx_held", 32'(rob_if.alloc_rob_idx_o), 32'd0);
        checkOutput("s2_still_full", 32'(rob_if.alloc_ready_o), 32'd0);
        doWb(0, 0);
        checkOutput("s2_no_commit_yet", 32'(rob_if.commit_valid_o), 32'd0);
        doIdle();
        checkOutput("s2_commit", 32'(rob_if.commit_valid_o), 32'd1);
        checkOutput("s2_phy", 32'(rob_if.rob_update_arat_phy_o), 32'd64);
        checkOutput("s2_ready", 32'(rob_if.alloc_ready_o), 32'd1);
        doFlush();
        checkOutput("s2_flushed", 32'(rob_if.empty_o), 32'd1);

        $display("[TB] store without destination");
        doAlloc(0, 0, 9, 20, 9);
        doWb(0, 0);
        doIdle();
        checkOutput("s3_commit", 32'(rob_if.commit_valid_o), 32'd1);
        checkOutput("s3_arat_en", 32'(rob_if.rob_update_arat_en_o), 32'd0);
        checkOutput("s3_arc", 32'(rob_if.rob_update_arat_arc_o), 32'd0);
        checkOutput("s3_phy", 32'(rob_if.rob_update_arat_phy_o), 32'd0);

        $display("[TB] floating-point destination");
        doAlloc(1, 1, 3, 50, 3);
        doWb(1, 0);
        doIdle();
        checkOutput("s4_arat_en", 32'(rob_if.rob_update_arat_en_o), 32'd1);
        checkOutput("s4_fp", 32'(rob_if.rob_update_fp_reg_o), 32'd1);
        checkOutput("s4_phy", 32'(rob_if.rob_update_arat_phy_o), 32'd50);
        checkOutput("s4_arc", 32'(rob_if.rob_update_arat_arc_o), 32'd3);

        $display("[TB] exception behind a completed instruction");
        doAlloc(1, 0, 10, 30, 10);
        doAlloc(1, 0, 11, 31, 11);
        doWb(2, 0);
        doWb(3, 1);
        checkOutput("s5_commit", 32'(rob_if.commit_valid_o), 32'd1);
        checkOutput("s5_arc", 32'(rob_if.rob_update_arat_arc_o), 32'd10);
        doIdle();
        checkOutput("s5_flush", 32'(rob_if.flush_o), 32'd1);
        checkOutput("s5_no_arat", 32'(rob_if.rob_update_arat_en_o), 32'd0);
        checkOutput("s5_empty", 32'(rob_if.empty_o), 32'd1);
        doIdle();
        checkOutput("s5_flush_pulse", 32'(rob_if.flush_o), 32'd0);
        checkOutput("s5_idx", 32'(rob_if.alloc_rob_idx_o), 32'd0);

        $display("[TB] external flush against allocate and commit");
        doAlloc(1, 0, 12, 32, 12);
        doWb(0, 0);
        applyStimulus(1, 1, 1, 0, 20, 60, 20, 0, 0, 0);
        checkOutput("s6_no_commit", 32'(rob_if.commit_valid_o), 32'd0);
        checkOutput("s6_empty", 32'(rob_if.empty_o), 32'd1);
        checkOutput("s6_idx", 32'(rob_if.alloc_rob_idx_o), 32'd0);
        doAlloc(1, 0, 13, 33, 13);
        checkOutput("s6_next_idx", 32'(rob_if.alloc_rob_idx_o), 32'd1);
        doWb(0, 0);
        doIdle();
        checkOutput("s6_commit_arc", 32'(rob_if.rob_update_arat_arc_o), 32'd13);
        doIdle();
        doIdle();

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/sy_ppl_rob_commit.md
Name: sy_ppl_rob_commit

Overview:
- In-order reorder buffer and commit unit. It is the retirement end of the rename interface.
- Accepts renamed instructions from rename/dispatch and tracks writeback completion.
- Retires at most one instruction per cycle, in program order.
- Drives the architectural-RAT/free-list update port (rob_update_arat_*) consumed by rename. Raises a pipeline flush when an excepting instruction reaches the head.

Parameters:
- ROB_DEPTH, 16, number of entries; must be a power of two and at least 2.
- ROB_IDX_WTH, $clog2(ROB_DEPTH), entry index width; derived, not overridden.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- flush_i  in  1  external flush (branch mispredict); clears all entries
- alloc_en_i  in  1  allocate one entry this cycle
- alloc_ready_o  out  1  ROB not full
- alloc_rob_idx_o  out  ROB_IDX_WTH  index given to the allocating instruction (tail pointer)
- alloc_rdst_en_i  in  1  instruction writes a destination register
- alloc_rdst_fp_i  in  1  destination is an FP register
- alloc_arc_rdst_i  in  5  architectural destination
- alloc_phy_rdst_i  in  PHY_REG_WTH  newly allocated physical destination
- alloc_phy_old_i  in  PHY_REG_WTH  previous mapping of the destination
- wb_en_i  in  1  writeback completion strobe
- wb_rob_idx_i  in  ROB_IDX_WTH  entry completing
- wb_exc_i  in  1  completing instruction raised an exception
- rob_update_arat_en_o  out  1  commit with register update
- rob_update_fp_reg_o  out  1  committed destination is FP
- rob_update_arat_arc_o  out  5  committed architectural destination
- rob_update_arat_phy_o  out  PHY_REG_WTH  committed physical destination
- rob_update_arat_old_phy_o  out  PHY_REG_WTH  physical register to free
- commit_valid_o  out  1  one instruction retired
- flush_o  out  1  exception flush request
- empty_o  out  1  no valid entries

Behaviour:
- One clock. Reset is synchronous and active-high. On rst_i: head, tail and count are 0; all valid and done bits are cleared; every output is 0 except alloc_ready_o=1 and empty_o=1.
- Entry fields: valid, done, exc, rdst_en, fp, arc, phy, old_phy.
- Allocate:
  - Fires when alloc_en_i && alloc_ready_o.
  - Writes the entry at tail and sets valid=1, done=0. Tail increments and wraps modulo ROB_DEPTH.
  - alloc_ready_o = (count != ROB_DEPTH), computed from the current-cycle count only. A same-cycle commit does not free a slot for allocation.
  - alloc_en_i while not ready is ignored.
- Writeback:
  - wb_en_i on a valid entry sets done=1 and exc=wb_exc_i at the clock edge.
  - wb_en_i on an invalid entry is ignored.
- Commit decision (cycle N):
  - Condition: head entry valid && done.
  - If exc=0: registered outputs assert in cycle N+1. commit_valid_o=1; rob_update_arat_en_o = rdst_en; the remaining fields are copied from the entry. The head entry is cleared and head increments at the end of N.
  - If exc=1: flush_o=1 in N+1 and no ARAT update. At the end of N all entries are cleared and head, tail and count are set to 0.
- Latency: writeback in cycle N → done visible in N+1 → commit outputs in N+2.
- All commit outputs are single-cycle pulses. Data fields are 0 when rob_update_arat_en_o=0.
- count update: +1 on allocate, −1 on commit, unchanged when both occur. Allocate and commit in the same cycle is legal when not full.
- Wrap-around: the full/empty distinction uses count, never a pointer compare.
- Precedence: rst_i > flush_i > exception flush > allocate / writeback / commit.
  - flush_i clears all state, as reset does, in the same edge. Allocate, writeback and commit in that cycle are dropped.
  - Outputs are 0 in the following cycle.

Optional Feature:
- Macro: SY_ROB_PERF_CNT_EN.
- With the macro defined, two extra outputs are added:
  - perf_commit_cnt_o (64 bits): increments per commit_valid_o.
  - perf_full_cycle_cnt_o (64 bits): increments each cycle with count==ROB_DEPTH.
  - Both counters reset on rst_i only and are not affected by flush.
- Without the macro, these ports and registers do not exist.

Decomposition:
- sy_pkg holds PHY_REG_WTH (already present) and a new rob_entry_t struct (valid, done, exc, rdst_en, fp, arc[4:0], phy, old_phy) plus ROB_DEPTH_DEFAULT.
- One sub-module: sy_ppl_rob_ptr. It manages head, tail, count, full and empty with wrap and precedence rules, so the pointer logic is verified separately.

Test Plan:
- Reset, then allocate 3 entries (arc 5/6/7, phy 40/41/42, old 5/6/7); writeback in order 2,0,1 → commits appear in order 0,1,2 on consecutive cycles with arc 5,6,7 and old_phy 5,6,7; rob_update_fp_reg_o=0.
- Allocate 16 with no writeback → alloc_ready_o=0 after the 16th. A 17th alloc_en_i is ignored (alloc_rob_idx_o remains 0). Writeback entry 0 → commit two cycles later, then alloc_ready_o=1.
- Entry with alloc_rdst_en_i=0 (store) completes → commit_valid_o=1, rob_update_arat_en_o=0, data fields 0.
- FP destination (arc 3, phy 50, old 3) commits → rob_update_arat_en_o=1 and rob_update_fp_reg_o=1.
- Entry 1 writes back with wb_exc_i=1 while entry 0 is done → entry 0 commits, then flush_o=1 the next cycle. Afterwards empty_o=1, with no ARAT update for entry 1.
- flush_i in the same cycle as alloc_en_i and a head commit → no commit pulse, empty_o=1 next cycle, and the next allocation gets index 0.
